tower_place_ctrl: RTL and testbench

Controller that sequences one tower placement on the 8x8 tower grid.
- On a placement request, reads the occupancy row from grid memory and checks the target cell.
- If the cell is free and the player can afford the tower, it sets the cell's bit with a read-modify-write.
- It then scans out every pixel of the cell square to the VGA plot interface through a valid/ready handshake.
- Sits between the cursor/input logic, the grid occupancy RAM (one 8-bit row per address) and the VGA adapter.

---
 rtl/tower_pkg.sv | 28 ++
 rtl/cell_pixel_scanner.sv | 40 ++++
 rtl/tower_place_ctrl.sv | 122 ++++++++++++
 tb/tb_tower_place_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tower_pkg.sv
// Shared types and constants for the tower placement path on the 8x8 grid.
package tower_pkg;

  localparam int GRID_N = 8;
  localparam int VGA_W  = 160;
  localparam int VGA_H  = 120;
  localparam int PX_W   = 4;

  localparam logic [2:0] DEF_TOWER_COLOUR  = 3'b010;
  localparam logic [2:0] DEF_BORDER_COLOUR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_DRAW,
    S_DONE,
    S_REJECT
  } state_t;

  // One-hot occupancy bit for a grid column.
  function automatic logic [GRID_N-1:0] col_mask(input logic [2:0] col);
    return GRID_N'(1) << col;
  endfunction

endpackage

// File: rtl/cell_pixel_scanner.sv
// Row-major px/py scan over one CELL_PX x CELL_PX cell; shared by the place, erase and cursor draw paths.
module cell_pixel_scanner
  import tower_pkg::*;
#(
  parameter int CELL_PX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            advance,
  output logic [PX_W-1:0] px,
  output logic [PX_W-1:0] py,
  output logic            last
);

  localparam logic [PX_W-1:0] MAX_IDX = PX_W'(CELL_PX - 1);

  logic px_last;

  assign px_last = (px == MAX_IDX);
  assign last    = px_last && (py == MAX_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px <= '0;
      py <= '0;
    end else if (start) begin
      px <= '0;
      py <= '0;
    end else if (advance) begin
      if (px_last) begin
        px <= '0;
        py <= last ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tower_place_ctrl.sv
// Sequences one tower placement: occupancy read-modify-write, then cell fill to the VGA plotter.
// Optional macro TOWER_PLACE_OUTLINE_EN draws the cell edge in BORDER_COLOUR.
module tower_place_ctrl
  import tower_pkg::*;
#(
  parameter int         CELL_PX       = 15,
  parameter int         ORIGIN_X      = 0,
  parameter int         ORIGIN_Y      = 0,
  parameter logic [2:0] TOWER_COLOUR  = DEF_TOWER_COLOUR,
  parameter logic [2:0] BORDER_COLOUR = DEF_BORDER_COLOUR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_req,
  input  logic [2:0] cur_col,
  input  logic [2:0] cur_row,
  input  logic       gold_ok,
  output logic [2:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       plot,
  input  logic       plot_ready,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  output logic       busy,
  output logic       done,
  output logic       rejected
);

`ifdef TOWER_PLACE_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif

  localparam logic [PX_W-1:0] MAX_IDX = PX_W'(CELL_PX - 1);

  state_t state_reg, state_next;
  logic [2:0]      col_reg, row_reg;
  logic [7:0]      row_buf_reg;
  logic [PX_W-1:0] px, py;
  logic            scan_last, scan_start, scan_advance;
  logic            on_edge;
  logic [2:0]      pix_colour;

  cell_pixel_scanner #(.CELL_PX(CELL_PX)) u_scanner (
    .clk     (clk),
    .rst     (reset),
    .start   (scan_start),
    .advance (scan_advance),
    .px      (px),
    .py      (py),
    .last    (scan_last)
  );

  assign mem_addr     = row_reg;
  assign busy         = (state_reg != S_IDLE);
  assign scan_advance = (state_reg == S_DRAW) && plot_ready;
  assign on_edge      = (px == '0) || (py == '0) || (px == MAX_IDX) || (py == MAX_IDX);
  assign pix_colour   = (OUTLINE && on_edge) ? BORDER_COLOUR : TOWER_COLOUR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      row_buf_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && place_req) begin
        col_reg <= cur_col;
        row_reg <= cur_row;
      end
      if (state_reg == S_WAIT) row_buf_reg <= mem_rdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    plot        = 1'b0;
    plot_x      = '0;
    plot_y      = '0;
    plot_colour = '0;
    done        = 1'b0;
    rejected    = 1'b0;
    scan_start  = 1'b0;
    case (state_reg)
      S_IDLE:  if (place_req) state_next = S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  state_next = S_CHECK;
      S_CHECK: state_next = (row_buf_reg[col_reg] || !gold_ok) ? S_REJECT : S_WRITE;
      S_WRITE: begin
        mem_we     = 1'b1;
        mem_wdata  = row_buf_reg | col_mask(col_reg);
        scan_start = 1'b1;
        state_next = S_DRAW;
      end
      S_DRAW: begin
        // Sums are formed at 9 bits then truncated to the port widths.
        plot        = 1'b1;
        plot_x      = 8'(9'(ORIGIN_X) + 9'(col_reg) * 9'(CELL_PX) + 9'(px));
        plot_y      = 7'(9'(ORIGIN_Y) + 9'(row_reg) * 9'(CELL_PX) + 9'(py));
        plot_colour = pix_colour;
        if (plot_ready && scan_last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_REJECT: begin
        rejected   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tower_place_ctrl.sv
// Self-checking bench for tower_place_ctrl: vector table plus pixel scoreboard and corner sequences.
module tb_tower_place_ctrl;

  localparam int CELL = 15;
  localparam int OX   = 0;
  localparam int OY   = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       place_req;
  logic [2:0] cur_col, cur_row;
  logic       gold_ok;
  logic [2:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       plot;
  logic       plot_ready = 1'b1;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       busy, done, rejected;

  tower_place_ctrl #(
    .CELL_PX(CELL), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .TOWER_COLOUR(3'b010), .BORDER_COLOUR(3'b111)
  ) dut (
    .clk(clk), .reset(reset), .place_req(place_req), .cur_col(cur_col),
    .cur_row(cur_row), .gold_ok(gold_ok), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .plot(plot), .plot_ready(plot_ready), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .busy(busy), .done(done), .rejected(rejected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_mode = 1'b0;

  logic [7:0]  ram [8];
  logic [17:0] sb [$];

  int we_cnt, done_cnt, rej_cnt, plot_cnt, stall_cnt;
  int we_cyc, rej_cyc, we_addr, we_data;
  bit stall_prev = 1'b0;
  logic [17:0] stall_val;

  typedef struct {
    int         col;
    int         row;
    logic [7:0] init;
    bit         gold;
    bit         rnd;
    bit         acc;
    logic [7:0] final_row;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input int px, input int py);
`ifdef TOWER_PLACE_OUTLINE_EN
    if (px == 0 || py == 0 || px == CELL - 1 || py == CELL - 1) return 3'b111;
`endif
    return 3'b010;
  endfunction

  always @(posedge clk) cyc++;

  // Synchronous-read occupancy RAM with one cycle of latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    #1;
    plot_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        we_cnt++;
        we_cyc  = cyc;
        we_addr = int'(mem_addr);
        we_data = int'(mem_wdata);
      end
      if (done) done_cnt++;
      if (rejected) begin
        rej_cnt++;
        rej_cyc = cyc;
      end
      if (done && rejected) chk("done_rejected_together", 1, 0);
      if (stall_prev) chk("stall_hold", int'({plot, plot_x, plot_y, plot_colour}), int'({1'b1, stall_val}));
      if (plot && plot_ready) begin
        plot_cnt++;
        if (sb.size() == 0) chk("unexpected_pixel", 1, 0);
        else chk("pixel", int'({plot_x, plot_y, plot_colour}), int'(sb.pop_front()));
      end
      if (plot && !plot_ready) stall_cnt++;
      stall_prev = plot && !plot_ready;
      stall_val  = {plot_x, plot_y, plot_colour};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_counts();
    we_cnt = 0; done_cnt = 0; rej_cnt = 0; plot_cnt = 0; stall_cnt = 0;
    we_cyc = -1; rej_cyc = -1; we_addr = -1; we_data = -1;
    sb.delete();
  endtask

  task automatic clear_ram();
    for (int r = 0; r < 8; r++) ram[r] = '0;
  endtask

  task automatic push_cell(input int col, input int row);
    for (int py = 0; py < CELL; py++)
      for (int px = 0; px < CELL; px++)
        sb.push_back({8'(OX + col * CELL + px), 7'(OY + row * CELL + py), exp_colour(px, py)});
  endtask

  task automatic issue(input int col, input int row, output int req_cyc);
    place_req = 1'b1;
    cur_col   = 3'(col);
    cur_row   = 3'(row);
    req_cyc   = cyc;
    @(negedge clk); #1;
    place_req = 1'b0;
  endtask

  task automatic wait_end();
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt + rej_cnt > 0) return;
      @(negedge clk); #1;
    end
    chk("timeout_waiting_end", 0, 1);
  endtask

  task automatic wait_pixels(input int n);
    for (int k = 0; k < 3000; k++) begin
      if (plot_cnt >= n) return;
      @(negedge clk); #1;
    end
    chk("timeout_waiting_pixels", plot_cnt, n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rejected"}, int'(rejected), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_plot_x"}, int'(plot_x), 0);
    chk({tag, "_plot_y"}, int'(plot_y), 0);
    chk({tag, "_colour"}, int'(plot_colour), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int req_cyc;
    clear_counts();
    clear_ram();
    ram[v.row] = v.init;
    gold_ok  = v.gold;
    rnd_mode = v.rnd;
    if (v.acc) push_cell(v.col, v.row);
    issue(v.col, v.row, req_cyc);
    wait_end();
    chk("done_count", done_cnt, v.acc ? 1 : 0);
    chk("reject_count", rej_cnt, v.acc ? 0 : 1);
    chk("write_count", we_cnt, v.acc ? 1 : 0);
    chk("plot_count", plot_cnt, v.acc ? CELL * CELL : 0);
    chk("scoreboard_left", sb.size(), 0);
    if (v.acc) begin
      chk("write_latency", we_cyc - req_cyc, 4);
      chk("write_addr", we_addr, v.row);
      chk("write_data", we_data, int'(v.final_row));
    end else begin
      chk("reject_latency", rej_cyc - req_cyc, 4);
    end
    @(negedge clk); #1;
    chk("ram_row", int'(ram[v.row]), int'(v.final_row));
    chk("busy_after_end", int'(busy), 0);
    $display("vec %0d col=%0d row=%0d gold=%0d rnd=%0d plots=%0d done=%0d rej=%0d stalls=%0d",
             idx, v.col, v.row, v.gold, v.rnd, plot_cnt, done_cnt, rej_cnt, stall_cnt);
  endtask

  initial begin
    int rc;
    vecs[0] = '{col: 3, row: 2, init: 8'h00, gold: 1, rnd: 0, acc: 1, final_row: 8'h08};
    vecs[1] = '{col: 3, row: 2, init: 8'h08, gold: 1, rnd: 0, acc: 0, final_row: 8'h08};
    vecs[2] = '{col: 5, row: 4, init: 8'h00, gold: 0, rnd: 0, acc: 0, final_row: 8'h00};
    vecs[3] = '{col: 7, row: 7, init: 8'h7f, gold: 1, rnd: 1, acc: 1, final_row: 8'hff};
    vecs[4] = '{col: 0, row: 1, init: 8'hfe, gold: 1, rnd: 1, acc: 1, final_row: 8'hff};
    vecs[5] = '{col: 6, row: 5, init: 8'h21, gold: 1, rnd: 1, acc: 1, final_row: 8'h61};

    reset = 1'b1; place_req = 1'b0; cur_col = '0; cur_row = '0; gold_ok = 1'b0;
    clear_ram();
    clear_counts();
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset after 100 accepted pixels, then a clean placement at (0,0).
    clear_counts(); clear_ram();
    gold_ok = 1'b1; rnd_mode = 1'b1;
    push_cell(4, 3);
    issue(4, 3, rc);
    wait_pixels(100);
    chk("pre_reset_pixels", plot_cnt, 100);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    sb.delete();
    @(negedge clk); #1;
    chk("midreset_plot_held_low", int'(plot), 0);
    chk("midreset_ram_kept", int'(ram[3]), 8'h10);
    reset = 1'b0;
    $display("reset mid-draw after %0d pixels", plot_cnt);
    clear_counts();
    rnd_mode = 1'b0;
    push_cell(0, 0);
    issue(0, 0, rc);
    wait_end();
    chk("post_reset_done", done_cnt, 1);
    chk("post_reset_plots", plot_cnt, CELL * CELL);
    chk("post_reset_sb_left", sb.size(), 0);
    @(negedge clk); #1;
    chk("post_reset_ram", int'(ram[0]), 8'h01);
    $display("post-reset place (0,0) plots=%0d done=%0d", plot_cnt, done_cnt);

    // Second request while drawing must be dropped.
    clear_counts(); clear_ram();
    gold_ok = 1'b1; rnd_mode = 1'b1;
    push_cell(2, 2);
    issue(2, 2, rc);
    wait_pixels(50);
    issue(1, 1, rc);
    wait_end();
    repeat (20) @(negedge clk);
    #1;
    chk("busy_req_done_count", done_cnt, 1);
    chk("busy_req_write_count", we_cnt, 1);
    chk("busy_req_write_addr", we_addr, 2);
    chk("busy_req_plots", plot_cnt, CELL * CELL);
    chk("busy_req_sb_left", sb.size(), 0);
    chk("busy_req_ram_row1", int'(ram[1]), 0);
    chk("busy_req_ram_row2", int'(ram[2]), 8'h04);
    chk("busy_req_idle", int'(busy), 0);
    chk("stalls_seen", int'(stall_cnt > 0), 1);
    $display("busy-request place (2,2) plots=%0d writes=%0d done=%0d stalls=%0d",
             plot_cnt, we_cnt, done_cnt, stall_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
